// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a one-entry skid
// buffer. in_ready and out_valid come straight from flops, so upstream never
// sees a combinational path from out_ready. A synchronous flush squashes all
// held entries and loads FLUSH_VALUE. A saturating counter tracks stall cycles
// for performance debug.
module pipe_stage_skid_reg #(
  parameter int unsigned                 DATA_WIDTH  = 64,
  parameter logic [DATA_WIDTH-1:0]       FLUSH_VALUE = '0,
  parameter int unsigned                 STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // The state encoding is the number of entries held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  main_q, main_d;
  logic [DATA_WIDTH-1:0]  skid_q, skid_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;

  // Next-state, payload routing and stall counting.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    if (flush) begin
      // Squash takes priority; a same-cycle in-transfer is dropped, while an
      // out-transfer still completes for downstream since out_data was valid.
      state_d = EMPTY;
      main_d  = FLUSH_VALUE;
      skid_d  = FLUSH_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_valid) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_valid && out_ready) begin
            main_d = in_data;
          end else if (in_valid) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_ready) begin
            // Main is left as-is; out_data holds its last value while empty.
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so in_valid/in_data are ignored.
          if (out_ready) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    if (out_valid_q && !out_ready && !flush &&
        (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end

    // Handshake outputs are registered copies of the decoded next state.
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // State, payload and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      // NOTE: payload registers are reset too, because out_data must read FLUSH_VALUE straight out of reset.
      main_q      <= FLUSH_VALUE;
      skid_q      <= FLUSH_VALUE;
      stall_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_q     <= stall_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = main_q;
  assign occupancy    = state_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed self-checking bench for pipe_stage_skid_reg: reset, streaming,
// skid fill/drain, flush, stall-counter saturation and asynchronous reset.
module tb_pipe_stage_skid_reg;

  localparam int unsigned    DW    = 64;
  localparam int unsigned    SW    = 4;
  localparam logic [DW-1:0]  FLUSH = 64'h0000_0000_0000_0013;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cycles;

  int n_checks;
  int n_fails;

  pipe_stage_skid_reg #(
    .DATA_WIDTH  (DW),
    .FLUSH_VALUE (FLUSH),
    .STALL_CNT_W (SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle 1 time unit so sampling and driving stay off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, ".out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, ".in_ready"},  {63'd0, in_ready},  64'd1);
    check({tag, ".out_data"},  out_data,           FLUSH);
    check({tag, ".occupancy"}, {62'd0, occupancy}, 64'd0);
    check({tag, ".stall"},     {60'd0, stall_cycles}, 64'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hAAAA_AAAA_AAAA_AAAA;
    reset     = 1'b0;

    // 1 Reset held with in_valid high and the clock running.
    repeat (3) step();
    check_idle_reset("reset");
    reset = 1'b1;

    // 2 Streaming at full throughput.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 64'h0123_4567_0000_0000 | 64'(i);
      step();
      check($sformatf("stream.data%0d", i), out_data, 64'h0123_4567_0000_0000 | 64'(i));
      check($sformatf("stream.valid%0d", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("stream.rdy%0d", i), {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream.drain_valid", {63'd0, out_valid}, 64'd0);
    check("stream.hold_data", out_data, 64'h0123_4567_0000_0008);
    check("stream.stall", {60'd0, stall_cycles}, 64'd0);

    // 3 Skid: A, B, C with out_ready low.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA;
    step();
    check("skid.occ_a", {62'd0, occupancy}, 64'd1);
    check("skid.data_a", out_data, 64'hA);
    check("skid.rdy_a", {63'd0, in_ready}, 64'd1);
    in_data = 64'hB;
    step();
    check("skid.occ_b", {62'd0, occupancy}, 64'd2);
    check("skid.rdy_b", {63'd0, in_ready}, 64'd0);
    check("skid.stall_b", {60'd0, stall_cycles}, 64'd1);
    in_data = 64'hC;
    step();
    check("skid.occ_c", {62'd0, occupancy}, 64'd2);
    check("skid.data_c", out_data, 64'hA);
    check("skid.stall_c", {60'd0, stall_cycles}, 64'd2);
    out_ready = 1'b1;
    step();   // A leaves, B moves into main, C ignored (in_ready was 0)
    check("skid.out_b", out_data, 64'hB);
    check("skid.occ_drain", {62'd0, occupancy}, 64'd1);
    check("skid.rdy_drain", {63'd0, in_ready}, 64'd1);
    step();   // B leaves, C accepted
    check("skid.out_c", out_data, 64'hC);
    check("skid.valid_c", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    step();   // C leaves
    check("skid.empty", {62'd0, occupancy}, 64'd0);
    check("skid.stall_end", {60'd0, stall_cycles}, 64'd2);

    // 4 Flush while FULL with payload D offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hE;
    step();
    in_data = 64'hF;
    step();
    check("flush.pre_occ", {62'd0, occupancy}, 64'd2);
    in_data = 64'hD;
    flush   = 1'b1;
    step();
    flush = 1'b0;
    check("flush.occ", {62'd0, occupancy}, 64'd0);
    check("flush.valid", {63'd0, out_valid}, 64'd0);
    check("flush.data", out_data, FLUSH);
    check("flush.rdy", {63'd0, in_ready}, 64'd1);
    check("flush.stall", {60'd0, stall_cycles}, 64'd3);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("flush.no_d%0d", i), {63'd0, out_valid}, 64'd0);
    end
    // Skid must have been cleared too: fill to FULL and drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h21;
    step();
    in_data = 64'h22;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("flush.refill_order", out_data, 64'h22);

    // 5 Stall counter saturation after a fresh reset.
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    check("cnt.cleared", {60'd0, stall_cycles}, 64'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h55;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("cnt.c%0d", i), {60'd0, stall_cycles},
            (i > 15) ? 64'd15 : 64'(i));
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("cnt.after_flush", {60'd0, stall_cycles}, 64'd15);
    check("cnt.flush_occ", {62'd0, occupancy}, 64'd0);

    // 6 Asynchronous reset while FULL, between edges.
    in_valid = 1'b1;
    in_data  = 64'h77;
    step();
    in_data = 64'h78;
    step();
    in_valid = 1'b0;
    check("areset.pre_occ", {62'd0, occupancy}, 64'd2);
    #2 reset = 1'b0;
    #1;
    check_idle_reset("areset");
    #1 reset = 1'b1;
    step();
    check("areset.stays_empty", {62'd0, occupancy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
